// File: rtl/instruction_encoder.sv
// ----------------------------------------------------------------------------
// instruction_encoder
//
// Packs one instruction per handshake into the 16-bit Simple RISC Machine
// format and writes the words to consecutive instruction-memory addresses,
// starting at BASE on every `start`. A session ends on a HALT write or when
// the last address has been written. Bundles with a reserved class or an
// out-of-range immediate are rejected: err pulses, err_count counts them,
// and the bundle is not written.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           begin a load session at BASE (honoured in IDLE / DONE)
//   in_valid        field bundle valid
//   in_ready        encoder can accept a bundle this cycle
//   in_class        0 MOVI, 1 MOVR, 2 ALU, 3 LDR, 4 STR, 5 HALT, 6-7 reserved
//   in_op           ALU op: ADD 00, CMP 01, AND 10, MVN 11
//   in_rn/rd/rm     register numbers
//   in_shift        shift field
//   in_imm          signed immediate (two's complement)
//   mem_addr        write address
//   mem_wdata       encoded word
//   mem_write       write request, held until mem_ack
//   mem_ack         memory accepted the word this cycle
//   done            session ended (HALT written or memory full)
//   full            session ended because the last address was written
//   err             one-cycle pulse after a rejected bundle
//   err_count       rejected bundles this session, saturating at 255
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module instruction_encoder #(
    parameter int          ADDR_W = 8,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [1:0]        in_op,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rm,
    input  logic [1:0]        in_shift,
    input  logic [15:0]       in_imm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_write,
    input  logic              mem_ack,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;  // DEPTH-1

    // Instruction classes as presented on in_class.
    localparam logic [2:0] CL_MOVI = 3'd0;
    localparam logic [2:0] CL_MOVR = 3'd1;
    localparam logic [2:0] CL_ALU  = 3'd2;
    localparam logic [2:0] CL_LDR  = 3'd3;
    localparam logic [2:0] CL_STR  = 3'd4;
    localparam logic [2:0] CL_HALT = 3'd5;

    // ALU ops whose register fields are forced to zero.
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_MVN = 2'b11;

    // Opcode of the HALT word; no other class produces 3'b111 in [15:13].
    localparam logic [2:0]  OPC_HALT  = 3'b111;
    localparam logic [15:0] HALT_WORD = 16'hE000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e state, state_nx;

    logic [15:0]       enc_word;
    logic              enc_legal;
    logic              imm_fits8;
    logic              imm_fits5;

    logic [ADDR_W-1:0] addr_nx;
    logic [15:0]       wdata_nx;
    logic              full_nx;
    logic              err_nx;
    logic [7:0]        err_count_nx;

    // ------------------------------------------------------------------------
    // Encoder. An immediate fits in k bits when bits [15:k-1] are all equal,
    // i.e. the upper bits are pure sign extension of bit k-1.
    // ------------------------------------------------------------------------
    assign imm_fits8 = (&in_imm[15:7]) | ~(|in_imm[15:7]);
    assign imm_fits5 = (&in_imm[15:4]) | ~(|in_imm[15:4]);

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (in_class)
            CL_MOVI: begin
                enc_word  = {3'b110, 2'b10, in_rn, in_imm[7:0]};
                enc_legal = imm_fits8;
            end
            CL_MOVR: begin
                enc_word  = {3'b110, 2'b00, 3'b000, in_rd, in_shift, in_rm};
                enc_legal = 1'b1;
            end
            CL_ALU: begin
                // CMP has no destination; MVN has no first operand.
                enc_word  = {3'b101, in_op,
                             (in_op == OP_MVN) ? 3'b000 : in_rn,
                             (in_op == OP_CMP) ? 3'b000 : in_rd,
                             in_shift, in_rm};
                enc_legal = 1'b1;
            end
            CL_LDR: begin
                enc_word  = {3'b011, 2'b00, in_rn, in_rd, in_imm[4:0]};
                enc_legal = imm_fits5;
            end
            CL_STR: begin
                enc_word  = {3'b100, 2'b00, in_rn, in_rd, in_imm[4:0]};
                enc_legal = imm_fits5;
            end
            CL_HALT: begin
                enc_word  = HALT_WORD;
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. in_ready, mem_write and done are pure
    // functions of the next state, so they are registered alongside it.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        addr_nx      = mem_addr;
        wdata_nx     = mem_wdata;
        full_nx      = full;
        err_nx       = 1'b0;
        err_count_nx = err_count;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx     = S_ACCEPT;
                    addr_nx      = BASE_ADDR;
                    full_nx      = 1'b0;
                    err_count_nx = '0;
                end
            end

            S_ACCEPT: begin
                if (in_valid) begin
                    if (enc_legal) begin
                        state_nx = S_WRITE;
                        wdata_nx = enc_word;
                    end else begin
                        err_nx = 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count_nx = err_count + 8'd1;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (mem_ack) begin
                    if (mem_wdata[15:13] == OPC_HALT) begin
                        state_nx = S_DONE;
                    end else if (mem_addr == LAST_ADDR) begin
                        // Stop before the address could wrap.
                        state_nx = S_DONE;
                        full_nx  = 1'b1;
                    end else begin
                        state_nx = S_ACCEPT;
                        addr_nx  = mem_addr + ADDR_W'(1);
                    end
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == S_ACCEPT);
            mem_write <= (state_nx == S_WRITE);
            done      <= (state_nx == S_DONE);
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            full      <= full_nx;
            err       <= err_nx;
            err_count <= err_count_nx;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// ----------------------------------------------------------------------------
// tb_instruction_encoder
//
// Directed bench for instruction_encoder. Two instances share the clock,
// reset and instruction field inputs:
//   dut   ADDR_W=8 : encodings, rejects, handshake timing, HALT, reset
//   sdut  ADDR_W=2 : memory-full stop and session restart
// Each instance has its own start / in_valid / mem_ack. Inputs are driven
// and outputs sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_class;
    logic [1:0]  in_op;
    logic [2:0]  in_rn, in_rd, in_rm;
    logic [1:0]  in_shift;
    logic [15:0] in_imm;

    // Main instance
    logic        start, in_valid, in_ready, mem_write, mem_ack;
    logic        done, full, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [7:0]  err_count;

    // Small instance
    logic        s_start, s_valid, s_ready, s_write, s_ack;
    logic        s_done, s_full, s_err;
    logic [1:0]  s_addr;
    logic [15:0] s_wdata;
    logic [7:0]  s_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ADDR_W(8), .BASE(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_op(in_op),
        .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
        .in_shift(in_shift), .in_imm(in_imm),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_ack(mem_ack),
        .done(done), .full(full), .err(err), .err_count(err_count)
    );

    instruction_encoder #(.ADDR_W(2), .BASE(0)) sdut (
        .clk(clk), .reset(reset), .start(s_start),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_class(in_class), .in_op(in_op),
        .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
        .in_shift(in_shift), .in_imm(in_imm),
        .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_write(s_write), .mem_ack(s_ack),
        .done(s_done), .full(s_full), .err(s_err), .err_count(s_err_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one bundle for a single cycle to the selected instance.
    task automatic send(input bit tgt, input logic [2:0] cls, input logic [1:0] op,
                        input logic [2:0] rn, input logic [2:0] rd, input logic [1:0] sh,
                        input logic [2:0] rm, input logic [15:0] imm);
        in_class = cls; in_op = op; in_rn = rn; in_rd = rd;
        in_shift = sh;  in_rm = rm; in_imm = imm;
        if (tgt) s_valid = 1'b1; else in_valid = 1'b1;
        step();
        s_valid  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic ack(input bit tgt);
        if (tgt) s_ack = 1'b1; else mem_ack = 1'b1;
        step();
        s_ack   = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Full reset-value check of the main instance.
    task automatic chk_reset_values(input string tag);
        chk({tag, " in_ready"},  16'(in_ready),  16'd0);
        chk({tag, " mem_write"}, 16'(mem_write), 16'd0);
        chk({tag, " mem_addr"},  16'(mem_addr),  16'd0);
        chk({tag, " mem_wdata"}, mem_wdata,      16'h0000);
        chk({tag, " done"},      16'(done),      16'd0);
        chk({tag, " full"},      16'(full),      16'd0);
        chk({tag, " err"},       16'(err),       16'd0);
        chk({tag, " err_count"}, 16'(err_count), 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_ack = 1'b0;
        in_class = '0; in_op = '0; in_rn = '0; in_rd = '0; in_rm = '0;
        in_shift = '0; in_imm = '0;

        // ---------------- reset ----------------
        step(); step();
        chk_reset_values("reset");
        reset = 1'b0;
        step();
        chk("idle in_ready", 16'(in_ready), 16'd0);

        // ---------------- start session ----------------
        start = 1'b1; step(); start = 1'b0;
        chk("start in_ready", 16'(in_ready), 16'd1);
        chk("start addr",     16'(mem_addr), 16'd0);

        // MOVI Rn=3, imm=-5 -> 0xD3FB at addr 0; ack in the same cycle
        send(0, 3'd0, 2'b00, 3'd3, 3'd0, 2'b00, 3'd0, 16'hFFFB);
        chk("movi write", 16'(mem_write), 16'd1);
        chk("movi data",  mem_wdata,      16'hD3FB);
        chk("movi addr",  16'(mem_addr),  16'd0);
        chk("movi ready", 16'(in_ready),  16'd0);
        ack(0);
        chk("movi ack write", 16'(mem_write), 16'd0);
        chk("movi ack ready", 16'(in_ready),  16'd1);
        chk("movi ack addr",  16'(mem_addr),  16'd1);

        // ALU CMP Rn=1 Rd=7 sh=01 Rm=2 -> 0xA90A
        send(0, 3'd2, 2'b01, 3'd1, 3'd7, 2'b01, 3'd2, 16'h0000);
        chk("cmp data", mem_wdata,     16'hA90A);
        chk("cmp addr", 16'(mem_addr), 16'd1);
        ack(0);

        // ALU MVN Rn=5 Rd=4 Rm=6 -> 0xB886
        send(0, 3'd2, 2'b11, 3'd5, 3'd4, 2'b00, 3'd6, 16'h0000);
        chk("mvn data", mem_wdata,     16'hB886);
        chk("mvn addr", 16'(mem_addr), 16'd2);
        ack(0);

        // LDR imm=16 is out of range: err pulse, no write, address held
        send(0, 3'd3, 2'b00, 3'd2, 3'd1, 2'b00, 3'd0, 16'h0010);
        chk("ldr16 err",       16'(err),       16'd1);
        chk("ldr16 err_count", 16'(err_count), 16'd1);
        chk("ldr16 write",     16'(mem_write), 16'd0);
        chk("ldr16 addr",      16'(mem_addr),  16'd3);
        chk("ldr16 ready",     16'(in_ready),  16'd1);
        step();
        chk("ldr16 err pulse end", 16'(err), 16'd0);

        // LDR imm=-16 is the lower bound -> 0x6230
        send(0, 3'd3, 2'b00, 3'd2, 3'd1, 2'b00, 3'd0, 16'hFFF0);
        chk("ldr-16 write", 16'(mem_write), 16'd1);
        chk("ldr-16 data",  mem_wdata,      16'h6230);
        chk("ldr-16 addr",  16'(mem_addr),  16'd3);
        ack(0);

        // Reserved class 6 is rejected
        send(0, 3'd6, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000);
        chk("rsvd err",       16'(err),       16'd1);
        chk("rsvd err_count", 16'(err_count), 16'd2);
        chk("rsvd write",     16'(mem_write), 16'd0);

        // MOVI imm=128 rejected, imm=-128 accepted -> 0xD080
        send(0, 3'd0, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0080);
        chk("movi128 err_count", 16'(err_count), 16'd3);
        send(0, 3'd0, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'hFF80);
        chk("movi-128 data", mem_wdata,     16'hD080);
        chk("movi-128 addr", 16'(mem_addr), 16'd4);
        ack(0);

        // STR Rn=7 Rd=0 imm=15 (upper bound) -> 0x870F
        send(0, 3'd4, 2'b00, 3'd7, 3'd0, 2'b00, 3'd0, 16'h000F);
        chk("str15 data", mem_wdata,     16'h870F);
        chk("str15 addr", 16'(mem_addr), 16'd5);
        ack(0);

        // start in ACCEPT is ignored
        start = 1'b1; step(); start = 1'b0;
        chk("start in accept addr",      16'(mem_addr),  16'd6);
        chk("start in accept err_count", 16'(err_count), 16'd3);

        // MOVR Rd=5 sh=10 Rm=3 -> 0xC0B3, ack delayed: write held 3 cycles
        send(0, 3'd1, 2'b00, 3'd0, 3'd5, 2'b10, 3'd3, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("movr held write", 16'(mem_write), 16'd1);
            chk("movr held data",  mem_wdata,      16'hC0B3);
            chk("movr held addr",  16'(mem_addr),  16'd6);
            start   = (i == 1);      // ignored in WRITE
            mem_ack = (i == 2);
            step();
        end
        start = 1'b0; mem_ack = 1'b0;
        chk("movr done write", 16'(mem_write), 16'd0);
        chk("movr done addr",  16'(mem_addr),  16'd7);
        chk("movr done ready", 16'(in_ready),  16'd1);

        // HALT -> 0xE000, then DONE without full
        send(0, 3'd5, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'h1234);
        chk("halt data", mem_wdata,     16'hE000);
        chk("halt addr", 16'(mem_addr), 16'd7);
        ack(0);
        chk("halt done",  16'(done),      16'd1);
        chk("halt full",  16'(full),      16'd0);
        chk("halt ready", 16'(in_ready),  16'd0);
        chk("halt write", 16'(mem_write), 16'd0);
        chk("halt addr2", 16'(mem_addr),  16'd7);
        send(0, 3'd0, 2'b00, 3'd1, 3'd0, 2'b00, 3'd0, 16'h0001);
        chk("done ignores valid", 16'(mem_write), 16'd0);

        // ---------------- new session, then reset during WRITE ----------------
        start = 1'b1; step(); start = 1'b0;
        chk("restart addr",      16'(mem_addr),  16'd0);
        chk("restart done",      16'(done),      16'd0);
        chk("restart err_count", 16'(err_count), 16'd0);
        send(0, 3'd0, 2'b00, 3'd1, 3'd0, 2'b00, 3'd0, 16'h0001);
        chk("pre-reset write", 16'(mem_write), 16'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk_reset_values("midreset");
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("post-reset ack write", 16'(mem_write), 16'd0);
        chk("post-reset ack addr",  16'(mem_addr),  16'd0);
        chk("post-reset ack ready", 16'(in_ready),  16'd0);

        // ---------------- ADDR_W=2: fill memory ----------------
        s_start = 1'b1; step(); s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1, 3'd1, 2'b00, 3'd0, 3'(i), 2'b00, 3'd1, 16'h0000);
            chk("fill addr",  16'(s_addr),  16'(i));
            chk("fill write", 16'(s_write), 16'd1);
            ack(1);
        end
        chk("full done",  16'(s_done),  16'd1);
        chk("full full",  16'(s_full),  16'd1);
        chk("full ready", 16'(s_ready), 16'd0);
        chk("full addr",  16'(s_addr),  16'd3);
        s_start = 1'b1; step(); s_start = 1'b0;
        chk("refill addr",  16'(s_addr),  16'd0);
        chk("refill done",  16'(s_done),  16'd0);
        chk("refill full",  16'(s_full),  16'd0);
        chk("refill ready", 16'(s_ready), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Inverse of the instruction decoder: accepts one instruction at a time as separate fields (class, op, register numbers, shift, signed immediate), packs them into the 16-bit Simple RISC Machine format, and writes the words sequentially into instruction memory. It sits between the test/program-load front end and the instruction RAM. It range-checks immediates against the 5-bit and 8-bit sign-extension rules. It stops on HALT or when memory is full.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width; DEPTH = 2^ADDR_W words
- BASE, 0, first write address after `start`

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a load session at BASE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_class  in  3  0 MOVI, 1 MOVR, 2 ALU, 3 LDR, 4 STR, 5 HALT; 6–7 reserved
- in_op  in  2  ALU op (ADD 00, CMP 01, AND 10, MVN 11)
- in_rn, in_rd, in_rm  in  3 each  register numbers
- in_shift  in  2  shift field
- in_imm  in  16  signed immediate (two's complement)
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  encoded word
- mem_write  out  1  write request, held until mem_ack
- mem_ack  in  1  memory accepted the word this cycle
- done  out  1  session ended (HALT written or memory full)
- full  out  1  session ended because the last address was written
- err  out  1  one-cycle pulse: bundle rejected
- err_count  out  8  rejected bundles this session, saturating at 255

## Operation
- Encodings, with [15:13] opcode and [12:11] op:
  - MOVI: 110,10,Rn,imm8.
  - MOVR: 110,00,000,Rd,sh,Rm.
  - ALU: 101,op,Rn,Rd,sh,Rm. For CMP, Rd is forced to 000. For MVN, Rn is forced to 000.
  - LDR: 011,00,Rn,Rd,imm5.
  - STR: 100,00,Rn,Rd,imm5.
  - HALT: 111,00, all remaining bits 0.
- Range checks:
  - MOVI requires in_imm in −128..127; imm8 = in_imm[7:0].
  - LDR/STR require in_imm in −16..15; imm5 = in_imm[4:0].
  - Legal iff in_imm[15:k-1] is all equal, for k = 8 or 5.
  - in_imm is ignored for other classes.
- A reserved class or out-of-range immediate is rejected:
  - err pulses one cycle after accept.
  - err_count increments.
  - No write occurs and the address does not advance.
  - The FSM stays in ACCEPT.
- FSM states:
  - IDLE: in_ready=0. `start` → ACCEPT; mem_addr←BASE, err_count←0, done←0, full←0.
  - ACCEPT: in_ready=1. in_valid & legal → WRITE; word latched into mem_wdata. Illegal → ACCEPT with err.
  - WRITE: mem_write=1, in_ready=0. On mem_ack:
    - HALT word → DONE.
    - Otherwise, mem_addr == DEPTH−1 → DONE with full←1.
    - Otherwise, mem_addr+1 → ACCEPT.
  - DONE: done=1, in_ready=0. `start` → ACCEPT (new session, same initialisation as IDLE).
- `start` is ignored in ACCEPT and WRITE.
- mem_addr arithmetic is ADDR_W-bit. It never wraps; the full stop occurs first.
- Reset mid-session:
  - Any in-flight write is abandoned; mem_write drops the next edge.
  - The FSM returns to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=0, mem_write=0, mem_addr=BASE, mem_wdata=0.
  - done=0, full=0, err=0, err_count=0.
- Handshake and latency:
  - Accept occurs on the edge where in_valid & in_ready.
  - mem_write rises on that edge, so the write is visible the cycle after accept.
  - mem_addr and mem_wdata are stable while mem_write=1.
  - mem_ack in the same cycle mem_write rises completes the write, so the minimum is 2 cycles per instruction.
  - in_ready returns the cycle after the acking edge.
  - mem_ack is ignored when mem_write=0.
- All outputs are registered; there are no combinational in→out paths.
- err is registered; it is asserted for exactly the cycle after the rejecting edge.

## Test plan
- Reset, start, then MOVI Rn=3, imm=−5 → mem_wdata 0xD3FB at addr 0, one cycle after accept; with mem_ack the same cycle, in_ready=1 the next cycle.
- ALU CMP Rn=1, Rd=7, sh=01, Rm=2 → 0xA90A (Rd forced 0); MVN Rn=5, Rd=4, Rm=6 → 0xB886.
- LDR Rn=2, Rd=1, imm=16 → err pulse, err_count=1, no mem_write, mem_addr unchanged; then imm=−16 → 0x6230.
- ADDR_W=2, four legal non-HALT instructions → addresses 0..3 written, then done=1, full=1, in_ready=0; start → mem_addr=0, done=0, full=0.
- Stream MOVR then HALT with mem_ack delayed 3 cycles → mem_write held 3 cycles with stable data; HALT word 0xE000 written, then done=1, full=0.
- Reset asserted while in WRITE → next cycle mem_write=0, in_ready=0, all outputs at reset values; mem_ack afterwards has no effect.
